bcd_down_counter: RTL

- Multi-digit BCD down-counter (countdown timer). It is the counterpart of the lab's up-counting bcd_counter.
- Loads a BCD value, decrements it once per qualified tick while running, stops at 0000, and emits a one-cycle done pulse.
- Sits between a tick/prescaler source and the 7-segment display path.
- Its digits are a cascade of single-digit down-counters chained by borrow.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_down_digit.sv | 35 +++
 rtl/bcd_down_counter.sv | 116 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD down-counter slice.
//   BCD_W   : width of one BCD digit
//   BCD_MAX : largest legal BCD digit value
//   state_t : countdown FSM state encoding
//   clamp_bcd() : forces a non-BCD nibble (>9) to 9
package bcd_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit down-counter, one stage of the borrow cascade.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset, clears the digit
//   load       : captures load_digit (clamped to 9)
//   load_digit : value to load for this digit
//   borrow_in  : decrement request from the stage below (or the tick)
//   digit      : current digit value (registered)
//   is_zero    : digit == 0, feeds the borrow chain of higher digits
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             is_zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= clamp_bcd(load_digit);
        end else if (borrow_in) begin
            // Borrowing from a zero digit wraps it to 9.
            digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign is_zero = (digit == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer.
// Loads a BCD value, decrements once per tick while running, stops at
// zero and pulses done for one cycle.
// Ports:
//   clk      : system clock
//   reset    : synchronous active-high reset
//   load     : capture load_val into count, return to IDLE
//   load_val : BCD load value, digit 0 at bits [3:0]
//   start    : begin/resume counting (ignored when count is zero)
//   stop     : pause counting
//   tick     : single-cycle count enable
//   count    : current BCD value
//   running  : high while in RUN
//   done     : one-cycle pulse after the count reaches zero
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    tick,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    running,
    output logic                    done
);

    state_t           state;
    logic [BCD_W-1:0] digits [DIGITS];
    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] borrow;
    logic             dec_en;
    logic             upper_zero;
    logic             count_is_one;
    logic             count_nonzero;

    // A tick only counts in RUN and when nothing of higher priority is active.
    assign dec_en = (state == RUN) && tick && !stop && !load && !reset;

    // Borrow ripples upward through every digit that is currently zero.
    always_comb begin
        borrow    = '0;
        borrow[0] = dec_en;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            borrow[i] = borrow[i-1] & is_zero[i-1];
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            upper_zero = upper_zero & is_zero[i];
        end
    end

    // The decrement that reaches zero is the one applied to a count of 1.
    assign count_is_one  = upper_zero && (digits[0] == 4'd1);
    assign count_nonzero = !(&is_zero);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_val[g*BCD_W +: BCD_W]),
            .borrow_in  (borrow[g]),
            .digit      (digits[g]),
            .is_zero    (is_zero[g])
        );
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            count[i*BCD_W +: BCD_W] = digits[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= IDLE;
                running <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (stop) begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end else if (tick && count_is_one) begin
                            state   <= IDLE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                    default: begin
                        if (start && !stop && count_nonzero) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
